// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS multi-cycle controller.
package mips_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned FC_W  = 2;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;

    localparam logic [FC_W-1:0] FC_NONE    = 2'd0;
    localparam logic [FC_W-1:0] FC_ZERO    = 2'd1;
    localparam logic [FC_W-1:0] FC_KREG    = 2'd2;
    localparam logic [FC_W-1:0] FC_ILLEGAL = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_K0   = 5'd26;
    localparam logic [4:0] REG_K1   = 5'd27;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic reg_dst;    // 1: destination is rd, 0: rt
        logic reg_write;
        logic alu_src;    // 1: operand B is the extended immediate
        logic sign_ext;
        logic legal;
    } dec_t;

endpackage

// File: rtl/mips_main_decoder.sv
// Combinational opcode decoder for the supported R-type and I-type ALU ops.
module mips_main_decoder
    import mips_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output dec_t             dec_c_o
);

    // Opcode to control-field lookup; anything unlisted is illegal.
    always_comb begin
        dec_c_o = '0;
        case (opcode_i)
            OP_RTYPE: begin
                dec_c_o.reg_dst   = 1'b1;
                dec_c_o.reg_write = 1'b1;
                dec_c_o.legal     = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec_c_o.reg_write = 1'b1;
                dec_c_o.alu_src   = 1'b1;
                dec_c_o.sign_ext  = 1'b1;
                dec_c_o.legal     = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_c_o.reg_write = 1'b1;
                dec_c_o.alu_src   = 1'b1;
                dec_c_o.legal     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle READ/EXEC/WB sequencer with destination-register protection.
// Optional feature macro: MIPS_CTRL_KREG_PROTECT_EN ($k0/$k1 write protection).
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              rf_rd_en,
    output logic [RA_W-1:0]   rf_rd_addr_a,
    output logic [RA_W-1:0]   rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b,
    output logic [31:0]       alu_instr,
    output logic [DATA_W-1:0] alu_op_a,
    output logic [DATA_W-1:0] alu_op_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rf_wr_en,
    output logic [RA_W-1:0]   rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              done,
    output logic              fault,
    output logic [FC_W-1:0]   fault_code
);

    state_e              state_q;
    logic                ready_q, rd_en_q, wr_en_q, done_q, fault_q;
    logic [31:0]         instr_q;
    logic [RA_W-1:0]     rd_addr_a_q, rd_addr_b_q, dest_q, wr_addr_q;
    logic                use_imm_q;
    logic [DATA_W-1:0]   imm_ext_q, op_a_q, op_b_q, wr_data_q;
    logic [FC_W-1:0]     fault_pend_q, fault_code_q;

    dec_t                dec;
    logic [RA_W-1:0]     dest;
    logic [DATA_W-1:0]   imm_ext, op_b_exec;
    logic [FC_W-1:0]     fault_chk;
    logic                in_exec;

    mips_main_decoder u_dec (
        .opcode_i (instr_q[31:26]),
        .dec_c_o  (dec)
    );

    // Destination select and immediate extension from the latched instruction.
    always_comb begin
        dest    = dec.reg_dst ? RA_W'(instr_q[15:11]) : RA_W'(instr_q[20:16]);
        imm_ext = dec.sign_ext ? {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]}
                               : {{(DATA_W-16){1'b0}}, instr_q[15:0]};
    end

    // Protection check, highest priority first: illegal, $zero, $k0/$k1.
    always_comb begin
        fault_chk = FC_NONE;
        if (!(dec.legal && dec.reg_write)) begin
            fault_chk = FC_ILLEGAL;
        end else if (dest == RA_W'(REG_ZERO)) begin
            fault_chk = FC_ZERO;
        end
`ifdef MIPS_CTRL_KREG_PROTECT_EN
        else if (dest == RA_W'(REG_K0) || dest == RA_W'(REG_K1)) begin
            fault_chk = FC_KREG;
        end
`endif
    end

    // Read data arrives during EXEC, so operands pass through then and hold after.
    always_comb begin
        in_exec   = (state_q == ST_EXEC);
        op_b_exec = use_imm_q ? imm_ext_q : rf_rd_data_b;
        alu_op_a  = in_exec ? rf_rd_data_a : op_a_q;
        alu_op_b  = in_exec ? op_b_exec : op_b_q;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            instr_q      <= '0;
            rd_addr_a_q  <= '0;
            rd_addr_b_q  <= '0;
            dest_q       <= '0;
            wr_addr_q    <= '0;
            use_imm_q    <= 1'b0;
            imm_ext_q    <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            wr_data_q    <= '0;
            fault_pend_q <= FC_NONE;
            fault_code_q <= FC_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q      <= instr;
                        rd_addr_a_q  <= RA_W'(instr[25:21]);
                        rd_addr_b_q  <= RA_W'(instr[20:16]);
                        rd_en_q      <= 1'b1;
                        ready_q      <= 1'b0;
                        fault_code_q <= FC_NONE;
                        state_q      <= ST_READ;
                    end
                end
                ST_READ: begin
                    rd_en_q      <= 1'b0;
                    use_imm_q    <= dec.alu_src;
                    imm_ext_q    <= imm_ext;
                    dest_q       <= dest;
                    fault_pend_q <= fault_chk;
                    state_q      <= ST_EXEC;
                end
                ST_EXEC: begin
                    op_a_q       <= rf_rd_data_a;
                    op_b_q       <= op_b_exec;
                    wr_addr_q    <= dest_q;
                    wr_data_q    <= alu_result;
                    wr_en_q      <= (fault_pend_q == FC_NONE);
                    done_q       <= 1'b1;
                    fault_q      <= (fault_pend_q != FC_NONE);
                    fault_code_q <= fault_pend_q;
                    state_q      <= ST_WB;
                end
                ST_WB: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready  = ready_q;
    assign rf_rd_en     = rd_en_q;
    assign rf_rd_addr_a = rd_addr_a_q;
    assign rf_rd_addr_b = rd_addr_b_q;
    assign alu_instr    = instr_q;
    assign rf_wr_en     = wr_en_q;
    assign rf_wr_addr   = wr_addr_q;
    assign rf_wr_data   = wr_data_q;
    assign done         = done_q;
    assign fault        = fault_q;
    assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: register file and ALU environment, reference model, directed and random stimulus.
module tb_mips_multicycle_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RA_W   = 5;

    logic              clk;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              rf_rd_en;
    logic [RA_W-1:0]   rf_rd_addr_a, rf_rd_addr_b;
    logic [DATA_W-1:0] rf_rd_data_a, rf_rd_data_b;
    logic [31:0]       alu_instr;
    logic [DATA_W-1:0] alu_op_a, alu_op_b, alu_result;
    logic              rf_wr_en;
    logic [RA_W-1:0]   rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              done, fault;
    logic [1:0]        fault_code;

    mips_multicycle_ctrl #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .rf_rd_en     (rf_rd_en),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .alu_instr    (alu_instr),
        .alu_op_a     (alu_op_a),
        .alu_op_b     (alu_op_b),
        .alu_result   (alu_result),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .done         (done),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Simple MIPS ALU used as the environment and by the model.
    function automatic logic [31:0] alu_fn(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h22, 6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = {31'b0, $signed(a) < $signed(b)};
                6'h2B: r = {31'b0, a < b};
                default: r = a + b;
            endcase
            6'h08, 6'h09: r = a + b;
            6'h0A: r = {31'b0, $signed(a) < $signed(b)};
            6'h0B: r = {31'b0, a < b};
            6'h0C: r = a & b;
            6'h0D: r = a | b;
            6'h0E: r = a ^ b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign alu_result = alu_fn(alu_instr, alu_op_a, alu_op_b);

    // Environment register file: synchronous read, write on rf_wr_en.
    logic [31:0] env_rf [32];
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rd_data_a <= env_rf[rf_rd_addr_a];
            rf_rd_data_b <= env_rf[rf_rd_addr_b];
        end
        if (rf_wr_en && rf_wr_addr != 5'd0)
            env_rf[rf_wr_addr] <= rf_wr_data;
    end

    // Reference model: phase counter since accept plus an architectural register array.
    logic [31:0] ref_rf [32];
    int          m_phase = 0;
    logic [31:0] m_instr, m_a, m_b, m_res;
    logic [4:0]  m_dest;
    logic [1:0]  m_fc = 2'd0;
    logic [1:0]  m_code = 2'd0;
    bit          m_legal;

    function automatic bit is_legal(input logic [5:0] op);
        return (op == 6'h00) || (op >= 6'h08 && op <= 6'h0E);
    endfunction

    function automatic logic [1:0] code_of(input logic [31:0] ins);
        logic [4:0] d;
        d = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
        if (!is_legal(ins[31:26])) return 2'd3;
        if (d == 5'd0) return 2'd1;
`ifdef MIPS_CTRL_KREG_PROTECT_EN
        if (d == 5'd26 || d == 5'd27) return 2'd2;
`endif
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_fc    = 2'd0;
        end else begin
            case (m_phase)
                0: if (instr_valid) begin
                    m_instr = instr;
                    m_fc    = 2'd0;
                    m_legal = is_legal(instr[31:26]);
                    m_dest  = (instr[31:26] == 6'h00) ? instr[15:11] : instr[20:16];
                    m_a     = ref_rf[instr[25:21]];
                    if (instr[31:26] == 6'h00)
                        m_b = ref_rf[instr[20:16]];
                    else if (instr[31:26] >= 6'h08 && instr[31:26] <= 6'h0B)
                        m_b = {{16{instr[15]}}, instr[15:0]};
                    else
                        m_b = {16'h0, instr[15:0]};
                    m_res   = alu_fn(instr, m_a, m_b);
                    m_phase = 1;
                end
                1: m_phase = 2;
                2: begin
                    m_code  = code_of(m_instr);
                    m_fc    = m_code;
                    m_phase = 3;
                end
                default: begin
                    if (m_code == 2'd0) ref_rf[m_dest] = m_res;
                    m_phase = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("instr_ready", {31'b0, instr_ready}, {31'b0, m_phase == 0});
            chk("rf_rd_en", {31'b0, rf_rd_en}, {31'b0, m_phase == 1});
            chk("done", {31'b0, done}, {31'b0, m_phase == 3});
            chk("rf_wr_en", {31'b0, rf_wr_en}, {31'b0, m_phase == 3 && m_code == 2'd0});
            chk("fault_code", {30'b0, fault_code}, {30'b0, m_fc});
            if (m_phase == 1) begin
                chk("rd_addr_a", {27'b0, rf_rd_addr_a}, {27'b0, m_instr[25:21]});
                chk("rd_addr_b", {27'b0, rf_rd_addr_b}, {27'b0, m_instr[20:16]});
            end
            if (m_phase == 2) begin
                chk("alu_instr", alu_instr, m_instr);
                chk("alu_op_a", alu_op_a, m_a);
                if (m_legal) chk("alu_op_b", alu_op_b, m_b);
            end
            if (m_phase == 3) begin
                chk("fault", {31'b0, fault}, {31'b0, m_code != 2'd0});
                if (m_code == 2'd0) begin
                    chk("wr_addr", {27'b0, rf_wr_addr}, {27'b0, m_dest});
                    chk("wr_data", rf_wr_data, m_res);
                end
            end
        end
    end

    // Wait (bounded) for the DUT to take the currently offered instruction.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (instr_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [31:0] w);
        instr_valid = 1'b1;
        instr       = w;
        wait_accept();
        instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 9) op = 6'($urandom_range(15, 63));
        else if (sel == 8) op = 6'h00;
        else op = 6'(sel + 7);
        if (op == 6'h07) op = 6'h00;
        w[31:26] = op;
        if ($urandom_range(0, 3) == 0) begin
            sel = $urandom_range(0, 2);
            w[15:11] = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd26 : 5'd27;
            w[20:16] = w[15:11];
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            env_rf[i] = (i == 0) ? 32'd0 : $urandom;
            ref_rf[i] = env_rf[i];
        end
        env_rf[2] = 32'd1;
        ref_rf[2] = 32'd1;
        rf_rd_data_a = '0;
        rf_rd_data_b = '0;

        // Reset with an instruction offered: reset must win.
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = 32'h3442_1862;
        @(posedge clk);
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_rd_addr_a", {27'b0, rf_rd_addr_a}, 32'd0);
        chk("rst_rd_addr_b", {27'b0, rf_rd_addr_b}, 32'd0);
        chk("rst_alu_instr", alu_instr, 32'd0);
        chk("rst_op_a", alu_op_a, 32'd0);
        chk("rst_op_b", alu_op_b, 32'd0);
        chk("rst_wr_addr", {27'b0, rf_wr_addr}, 32'd0);
        chk("rst_wr_data", rf_wr_data, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        instr_valid = 1'b0;

        // ori $2,$2,0x1862 with $2 = 1.
        send(32'h3442_1862);
        @(negedge clk);
        chk("ori_rd_addr_a", {27'b0, rf_rd_addr_a}, 32'd2);
        @(negedge clk);
        chk("ori_op_a", alu_op_a, 32'h0000_0001);
        chk("ori_op_b", alu_op_b, 32'h0000_1862);
        @(negedge clk);
        chk("ori_wr_en", {31'b0, rf_wr_en}, 32'd1);
        chk("ori_wr_addr", {27'b0, rf_wr_addr}, 32'd2);
        chk("ori_wr_data", rf_wr_data, 32'h0000_1863);
        chk("ori_done", {31'b0, done}, 32'd1);
        chk("ori_fault", {31'b0, fault}, 32'd0);

        // add $0,$1,$2: $zero destination faults.
        send(32'h0022_0020);
        repeat (3) @(negedge clk);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_fault", {31'b0, fault}, 32'd1);
        chk("zero_code", {30'b0, fault_code}, 32'd1);
        chk("zero_wr_en", {31'b0, rf_wr_en}, 32'd0);
        @(negedge clk);
        chk("zero_code_hold", {30'b0, fault_code}, 32'd1);

        // Back-to-back with valid held: ori $3,$0,0xAB then addiu $4,$3,1.
        instr_valid = 1'b1;
        instr       = 32'h3403_00AB;
        wait_accept();
        instr = 32'h2464_0001;
        @(negedge clk);
        chk("b2b_ready_r", {31'b0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_e", {31'b0, instr_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_ready_w", {31'b0, instr_ready}, 32'd0);
        chk("b2b_first_data", rf_wr_data, 32'h0000_00AB);
        @(negedge clk);
        chk("b2b_ready_idle", {31'b0, instr_ready}, 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rd_addr_a", {27'b0, rf_rd_addr_a}, 32'd3);
        @(negedge clk);
        chk("b2b_op_a", alu_op_a, 32'h0000_00AB);
        @(negedge clk);
        chk("b2b_wr_addr", {27'b0, rf_wr_addr}, 32'd4);
        chk("b2b_wr_data", rf_wr_data, 32'h0000_00AC);

        // addi $26,$3,-1.
        send(32'h207A_FFFF);
        repeat (2) @(negedge clk);
        chk("k0_op_b", alu_op_b, 32'hFFFF_FFFF);
        @(negedge clk);
`ifdef MIPS_CTRL_KREG_PROTECT_EN
        chk("k0_code", {30'b0, fault_code}, 32'd2);
        chk("k0_wr_en", {31'b0, rf_wr_en}, 32'd0);
`else
        chk("k0_code", {30'b0, fault_code}, 32'd0);
        chk("k0_wr_en", {31'b0, rf_wr_en}, 32'd1);
        chk("k0_wr_addr", {27'b0, rf_wr_addr}, 32'd26);
        chk("k0_wr_data", rf_wr_data, 32'h0000_00AA);
`endif

        // Illegal opcode 0x3F.
        send(32'hFC00_0000);
        repeat (3) @(negedge clk);
        chk("ill_code", {30'b0, fault_code}, 32'd3);
        chk("ill_wr_en", {31'b0, rf_wr_en}, 32'd0);
        @(negedge clk);
        chk("ill_ready", {31'b0, instr_ready}, 32'd1);

        // Reset during EXEC.
        send(32'h3442_00F0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'b0, instr_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_done", {31'b0, done}, 32'd0);
            chk("mid_rst_wr_en", {31'b0, rf_wr_en}, 32'd0);
            @(negedge clk);
        end

        // Random traffic with junk valids while busy and random idle gaps.
        for (int n = 0; n < 250; n++) begin
            send(rand_instr());
            for (int c = 0; c < 3; c++) begin
                instr_valid = 1'($urandom_range(0, 1));
                instr       = $urandom;
                @(posedge clk);
                #1;
            end
            instr_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (6) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
